// File: rtl/note_tile_renderer.sv
// Tile-map glyph renderer: 32x16 map of 5-bit glyph codes, 2-stage pixel pipeline into the glyph ROM.
// Optional STAFF_LINES_EN overlays five horizontal staff lines on the tile region.
module note_tile_renderer #(
    parameter logic [9:0] ORIGIN_X = 10'd64,
    parameter logic [9:0] ORIGIN_Y = 10'd48
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pix_valid,
    input  logic       wr_en,
    input  logic [4:0] wr_col,
    input  logic [3:0] wr_row,
    input  logic [4:0] wr_code,
    input  logic       clear,
    output logic       busy,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic       pixel_valid_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state;
    logic [8:0] counter;

    logic [4:0] tile_mem [0:511];
    logic [4:0] ram_q;
    logic       we;
    logic [8:0] wa;
    logic [4:0] wd;

    logic       in_region;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [8:0] rd_index;

    logic       s0_inreg, s0_valid;
    logic [2:0] s0_row, s0_xoff;
    logic       s1_inreg, s1_valid;
    logic [2:0] s1_xoff;
    logic       glyph_bit;

    // Only the low bits of the local offsets are ever used, so subtract at that width.
    assign in_region = ({1'b0, DrawX} >= {1'b0, ORIGIN_X}) &&
                       ({1'b0, DrawX} <  ({1'b0, ORIGIN_X} + 11'd256)) &&
                       ({1'b0, DrawY} >= {1'b0, ORIGIN_Y}) &&
                       ({1'b0, DrawY} <  ({1'b0, ORIGIN_Y} + 11'd128));
    assign lx        = DrawX[7:0] - ORIGIN_X[7:0];
    assign ly        = DrawY[6:0] - ORIGIN_Y[6:0];
    assign rd_index  = {ly[6:3], lx[7:3]};
    assign glyph_bit = rom_data[3'd7 - s1_xoff];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= CLEAR;
            counter <= 9'd0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    counter <= counter + 9'd1;
                    if (counter == 9'd511) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (clear) begin
                        state   <= CLEAR;
                        counter <= 9'd0;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Clear sweep owns the write port while active; in IDLE a clear pulse drops any write.
    always_comb begin
        we = 1'b0;
        wa = counter;
        wd = 5'd0;
        if (!Reset) begin
            if (state == CLEAR) begin
                we = 1'b1;
            end else if (wr_en && !clear) begin
                we = 1'b1;
                wa = {wr_row, wr_col};
                wd = wr_code;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (we) tile_mem[wa] <= wd;
    end

    always_ff @(posedge Clk) begin
        if (Reset) ram_q <= 5'd0;
        else       ram_q <= tile_mem[rd_index];
    end

`ifdef STAFF_LINES_EN
    logic staff_hit, s0_staff, s1_staff;
    assign staff_hit = (ly[2:0] == 3'd4) && (ly[6:3] >= 4'd2) && (ly[6:3] <= 4'd6);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s0_staff <= 1'b0;
            s1_staff <= 1'b0;
        end else begin
            s0_staff <= staff_hit;
            s1_staff <= s0_staff;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s0_inreg        <= 1'b0;
            s0_valid        <= 1'b0;
            s0_row          <= 3'd0;
            s0_xoff         <= 3'd0;
            s1_inreg        <= 1'b0;
            s1_valid        <= 1'b0;
            s1_xoff         <= 3'd0;
            rom_addr        <= 8'h00;
            pixel_on        <= 1'b0;
            pixel_valid_out <= 1'b0;
        end else begin
            s0_inreg        <= in_region;
            s0_valid        <= pix_valid;
            s0_row          <= ly[2:0];
            s0_xoff         <= lx[2:0];
            s1_inreg        <= s0_inreg;
            s1_valid        <= s0_valid;
            s1_xoff         <= s0_xoff;
            rom_addr        <= {ram_q, s0_row};
            pixel_valid_out <= s1_valid;
`ifdef STAFF_LINES_EN
            pixel_on        <= s1_inreg & s1_valid & (glyph_bit | s1_staff);
`else
            pixel_on        <= s1_inreg & s1_valid & glyph_bit;
`endif
        end
    end

endmodule

// File: tb/tb_note_tile_renderer.sv
// Directed bench for note_tile_renderer with a small combinational glyph ROM model.
// Define STAFF_LINES_EN for both files to exercise the staff overlay.
module tb_note_tile_renderer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       pix_valid;
    logic       wr_en;
    logic [4:0] wr_col;
    logic [3:0] wr_row;
    logic [4:0] wr_code;
    logic       clear;
    logic       busy;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       pixel_on;
    logic       pixel_valid_out;

    int passCount = 0;
    int checkCount = 0;

    logic       obs_pix  [0:31];
    logic       obs_pv   [0:31];
    logic [7:0] obs_addr [0:31];

`ifdef STAFF_LINES_EN
    localparam bit STAFF = 1'b1;
`else
    localparam bit STAFF = 1'b0;
`endif

    note_tile_renderer #(.ORIGIN_X(10'd64), .ORIGIN_Y(10'd48)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code), .clear(clear),
        .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_on(pixel_on), .pixel_valid_out(pixel_valid_out)
    );

    always #5 Clk = ~Clk;

    // Glyph ROM model: code 1 is a solid block, code 2 lights only the outer columns.
    always_comb begin
        case (rom_addr[7:3])
            5'd1:    rom_data = 8'hFF;
            5'd2:    rom_data = 8'h81;
            default: rom_data = 8'h00;
        endcase
    end

    task automatic write_tile(input logic [4:0] col, input logic [3:0] row, input logic [4:0] code);
        wr_en = 1'b1; wr_col = col; wr_row = row; wr_code = code;
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    task automatic scan(input logic [9:0] x0, input logic [9:0] y, input int n, input logic v);
        for (int c = 0; c < n + 3; c++) begin
            if (c >= 2 && c - 2 < n) obs_addr[c-2] = rom_addr;
            if (c >= 3) begin
                obs_pix[c-3] = pixel_on;
                obs_pv[c-3]  = pixel_valid_out;
            end
            if (c < n) begin
                DrawX = x0 + 10'(c); DrawY = y; pix_valid = v;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge Clk);
        end
    endtask

    task automatic count_busy(output int edges);
        edges = 0;
        while (busy === 1'b1 && edges < 2000) begin
            @(negedge Clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        int edges;
        int lit;
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        checkCount++;
        if (busy !== 1'b1 || pixel_on !== 1'b0 || pixel_valid_out !== 1'b0 || rom_addr !== 8'h00)
            $display("[TB] FAIL reset_values: busy=%b pixel_on=%b pv=%b rom_addr=%h, want 1 0 0 00",
                     busy, pixel_on, pixel_valid_out, rom_addr);
        else passCount++;
        Reset = 1'b0;
        count_busy(edges);
        checkCount++;
        if (edges !== 512) $display("[TB] FAIL reset_clear_len: busy edges=%0d want 512", edges);
        else passCount++;

        lit = 0;
        for (int y = 40; y < 180; y++) begin
            for (int x = 60; x < 324; x++) begin
                lit += int'(pixel_on);
                DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
                @(negedge Clk);
            end
        end
        pix_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lit += int'(pixel_on);
            @(negedge Clk);
        end
        checkCount++;
        if (lit !== (STAFF ? 5 * 256 : 0))
            $display("[TB] FAIL empty_scan: lit=%0d want %0d", lit, STAFF ? 5 * 256 : 0);
        else passCount++;
    endtask

    task automatic test_glyph_solid;
        write_tile(5'd0, 4'd0, 5'h01);
        scan(10'd64, 10'd51, 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (obs_addr[i] !== 8'h0B || obs_pix[i] !== 1'b1 || obs_pv[i] !== 1'b1)
                $display("[TB] FAIL solid_px%0d: addr=%h pix=%b pv=%b want 0b 1 1",
                         i, obs_addr[i], obs_pix[i], obs_pv[i]);
            else passCount++;
        end
    endtask

    task automatic test_glyph_edges;
        logic want;
        write_tile(5'd1, 4'd0, 5'h02);
        scan(10'd72, 10'd51, 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            want = (i == 0 || i == 7);
            checkCount++;
            if (obs_addr[i] !== 8'h13 || obs_pix[i] !== want)
                $display("[TB] FAIL edges_px%0d: addr=%h pix=%b want 13 %b",
                         i, obs_addr[i], obs_pix[i], want);
            else passCount++;
        end
    endtask

    task automatic test_boundaries;
        logic [9:0] bx [0:6];
        logic [9:0] by [0:6];
        logic       bv [0:6];
        logic       bw [0:6];
        bx = '{10'd63, 10'd320, 10'd64, 10'd64, 10'd319, 10'd64, 10'd319};
        by = '{10'd51, 10'd172, 10'd51, 10'd51, 10'd172, 10'd47, 10'd176};
        bv = '{1'b1,   1'b1,    1'b0,   1'b1,   1'b1,    1'b1,   1'b1};
        bw = '{1'b0,   1'b0,    1'b0,   1'b1,   1'b1,    1'b0,   1'b0};
        write_tile(5'd31, 4'd15, 5'h01);
        for (int i = 0; i < 7; i++) begin
            scan(bx[i], by[i], 1, bv[i]);
            checkCount++;
            if (obs_pix[0] !== bw[i])
                $display("[TB] FAIL bound%0d x=%0d y=%0d v=%b: pix=%b want %b",
                         i, bx[i], by[i], bv[i], obs_pix[0], bw[i]);
            else passCount++;
        end
    endtask

    task automatic test_clear_priority;
        int edges;
        wr_en = 1'b1; wr_col = 5'd2; wr_row = 4'd0; wr_code = 5'h01;
        clear = 1'b1;
        @(negedge Clk);
        wr_en = 1'b0; clear = 1'b0;
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL clear_busy_rise: busy=%b want 1", busy);
        else passCount++;

        edges = 0;
        while (busy === 1'b1 && edges < 2000) begin
            wr_en = (edges == 100);
            wr_col = 5'd0; wr_row = 4'd0; wr_code = 5'h01;
            clear = (edges == 300);
            @(negedge Clk);
            edges++;
        end
        wr_en = 1'b0; clear = 1'b0;
        checkCount++;
        if (edges !== 512) $display("[TB] FAIL clear_len: busy edges=%0d want 512", edges);
        else passCount++;

        scan(10'd64, 10'd51, 24, 1'b1);
        for (int i = 0; i < 24; i++) begin
            checkCount++;
            if (obs_addr[i] !== 8'h03 || obs_pix[i] !== 1'b0)
                $display("[TB] FAIL cleared_px%0d: addr=%h pix=%b want 03 0", i, obs_addr[i], obs_pix[i]);
            else passCount++;
        end
        scan(10'd319, 10'd172, 1, 1'b1);
        checkCount++;
        if (obs_pix[0] !== 1'b0) $display("[TB] FAIL cleared_corner: pix=%b want 0", obs_pix[0]);
        else passCount++;
    endtask

    task automatic test_staff;
        logic [9:0] sy [0:3];
        logic       sw [0:3];
        sy = '{10'd68, 10'd67, 10'd52, 10'd100};
        sw = '{STAFF, 1'b0, 1'b0, STAFF};
        for (int i = 0; i < 4; i++) begin
            scan(10'd100, sy[i], 1, 1'b1);
            checkCount++;
            if (obs_pix[0] !== sw[i])
                $display("[TB] FAIL staff_y%0d: pix=%b want %b", sy[i], obs_pix[0], sw[i]);
            else passCount++;
        end
    endtask

    task automatic test_reset_midclear;
        int edges;
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        repeat (200) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        count_busy(edges);
        checkCount++;
        if (edges !== 512) $display("[TB] FAIL midclear_reset_len: busy edges=%0d want 512", edges);
        else passCount++;
    endtask

    initial begin
        DrawX = '0; DrawY = '0; pix_valid = 1'b0;
        wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_code = '0; clear = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        test_reset;
        test_glyph_solid;
        test_glyph_edges;
        test_boundaries;
        test_clear_priority;
        test_staff;
        test_reset_midclear;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
